// File: rtl/tt_um_hu8785_countdown_timer.sv
// rtl/tt_um_hu8785_countdown_timer.sv - loadable prescaled countdown timer tile
module tt_um_hu8785_countdown_timer #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 4
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [3:0]       r_s1;
    logic [3:0]       r_s2;
    logic [3:0]       r_s3;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [PW-1:0]    r_presc;
    logic             r_running;
    logic             r_done;

    logic             w_load;
    logic             w_start;
    logic             w_pause;
    logic             w_auto;
    logic             w_tick;
    logic [WIDTH-1:0] w_load_val;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic [PW-1:0]    w_presc_nxt;
    logic             w_pulse;
    logic             w_unused;

    // Pin-level controls are asynchronous; load/start act on rising edges of the synced copy
    assign w_load     = r_s2[0] & ~r_s3[0];
    assign w_start    = r_s2[1] & ~r_s3[1];
    assign w_pause    = r_s2[2];
    assign w_auto     = r_s2[3];
    assign w_tick     = (r_presc == P_LAST);
    assign w_load_val = uio_in[WIDTH-1:0];

    // Two-flop synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 4'd0;
            r_s2 <= 4'd0;
            r_s3 <= 4'd0;
        end else begin
            r_s1 <= ui_in[3:0];
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Next-state decision: load beats everything, then start, then pause
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_presc_nxt  = r_presc;
        w_pulse      = 1'b0;
        if (w_load) begin
            w_count_nxt  = w_load_val;
            w_reload_nxt = w_load_val;
            w_presc_nxt  = '0;
            w_state_nxt  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start && (r_count != C_ZERO)) begin
                        w_presc_nxt = '0;
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_tick) begin
                        w_presc_nxt = '0;
                        if (r_count > C_ONE) begin
                            w_count_nxt = r_count - C_ONE;
                        end else if (r_count == C_ONE) begin
                            if (w_auto && (r_reload != C_ZERO)) begin
                                w_count_nxt = r_reload;
                                w_pulse     = 1'b1;
                            end else begin
                                w_count_nxt = C_ZERO;
                                w_state_nxt = S_DONE;
                            end
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (!w_pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    if (w_start && (r_reload != C_ZERO)) begin
                        w_count_nxt = r_reload;
                        w_presc_nxt = '0;
                        w_state_nxt = S_RUN;
                    end
                end
            endcase
        end
    end

    // State, counter and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_presc   <= w_presc_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_DONE) | w_pulse;
        end
    end

    assign uo_out   = {r_done, r_running, 6'(r_count)};
    assign uio_out  = 8'h00;
    assign uio_oe   = 8'h00;
    assign w_unused = &{1'b0, ena, ui_in[7:4], uio_in};

endmodule
